// File: rtl/mem_responder_if.sv
// LC-3b 16-bit memory port: request/response bundle between an initiator and a memory responder.
interface mem_responder_if;
  logic        read_b;
  logic        write_b;
  logic [1:0]  wmask_b;
  logic [15:0] address_b;
  logic [15:0] wdata_b;
  logic        resp_b;
  logic [15:0] rdata_b;
  logic        busy;

  modport master (
    output read_b, write_b, wmask_b, address_b, wdata_b,
    input  resp_b, rdata_b, busy
  );

  modport slave (
    input  read_b, write_b, wmask_b, address_b, wdata_b,
    output resp_b, rdata_b, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the LC-3b memory port: fixed-latency word store with byte-masked writes,
// one resp_b pulse per accepted request, registered rdata_b.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_responder_if.slave    bus
);

  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic [15:0] ADDR_USED_MASK = 16'(((32'd1 << (ADDR_W + 1)) - 32'd1) & 32'hFFFF_FFFE);

  if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 1..15");
  end
  if ((ADDR_W < 1) || (ADDR_W > 15)) begin : g_bad_addr_w
    $error("mem_responder: ADDR_W must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic                accept_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [15:0]         wdata_r, wdata_s;
  logic [1:0]          wmask_r, wmask_s;
  logic                op_rd_r, op_rd_s;
  logic                op_wr_r, op_wr_s;
  logic [15:0]         rd_word_s;
  logic                load_rd_s;
  logic [15:0]         rdata_r, rdata_s;
  logic                resp_r;
  logic                busy_r;
  logic [15:0]         mem_r [DEPTH];
  logic                unused_addr_s;

  function automatic logic [15:0] merge_word(input logic [15:0] old_word,
                                             input logic [15:0] new_word,
                                             input logic [1:0]  mask);
    logic [15:0] res;
    res[7:0]  = mask[0] ? new_word[7:0]  : old_word[7:0];
    res[15:8] = mask[1] ? new_word[15:8] : old_word[15:8];
    return res;
  endfunction

  // Byte-address bit 0 and the bits above the word index alias away.
  assign unused_addr_s = ^(bus.address_b & ~ADDR_USED_MASK);

  // Next-state and latency countdown.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.read_b || bus.write_b) begin
          accept_s = 1'b1;
          if (LATENCY == 1) begin
            state_s = RESP;
            cnt_s   = 4'd0;
          end else begin
            state_s = WAIT;
            cnt_s   = LAT_M1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_s = RESP;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Transaction fields (live inputs on acceptance, latched copy otherwise) and read-data load.
  always_comb begin
    addr_s  = addr_r;
    wdata_s = wdata_r;
    wmask_s = wmask_r;
    op_rd_s = op_rd_r;
    op_wr_s = op_wr_r;
    if (accept_s) begin
      addr_s  = bus.address_b[ADDR_W:1];
      wdata_s = bus.wdata_b;
      wmask_s = bus.wmask_b;
      op_rd_s = bus.read_b;
      op_wr_s = bus.write_b;
    end else begin
      addr_s  = addr_r;
    end
    rd_word_s = mem_r[addr_s];
    load_rd_s = (state_s == RESP) && (state_r != RESP) && op_rd_s;
    rdata_s   = rdata_r;
    // A combined read+write returns the word as it will look once the write commits.
    if (load_rd_s) begin
      if (op_wr_s) begin
        rdata_s = merge_word(rd_word_s, wdata_s, wmask_s);
      end else begin
        rdata_s = rd_word_s;
      end
    end else begin
      rdata_s = rdata_r;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      wdata_r <= 16'h0000;
      wmask_r <= 2'b00;
      op_rd_r <= 1'b0;
      op_wr_r <= 1'b0;
      rdata_r <= 16'h0000;
      resp_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      wmask_r <= wmask_s;
      op_rd_r <= op_rd_s;
      op_wr_r <= op_wr_s;
      rdata_r <= rdata_s;
      resp_r  <= (state_s == RESP);
      busy_r  <= (state_s != IDLE);
    end
  end

  // Storage survives reset; a write commits only while in RESP, so a reset beforehand drops it.
  always_ff @(posedge clk) begin
    if ((state_r == RESP) && op_wr_r) begin
      mem_r[addr_r] <= merge_word(mem_r[addr_r], wdata_r, wmask_r);
    end
  end

  assign bus.resp_b  = resp_r;
  assign bus.rdata_b = rdata_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (LATENCY 2, 4, 1) exercised one at a time.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  int          sel;
  logic        rd_d, wr_d;
  logic [15:0] addr_d, wdata_d;
  logic [1:0]  mask_d;
  logic        resp_s, busy_s;
  logic [15:0] rdata_s;
  int          checks = 0;
  int          errors = 0;

  mem_responder_if bus2 ();
  mem_responder_if bus4 ();
  mem_responder_if bus1 ();

  mem_responder #(.ADDR_W(8), .LATENCY(2)) u_dut2 (.clk(clk), .reset_n(rst_n[0]), .bus(bus2));
  mem_responder #(.ADDR_W(8), .LATENCY(4)) u_dut4 (.clk(clk), .reset_n(rst_n[1]), .bus(bus4));
  mem_responder #(.ADDR_W(8), .LATENCY(1)) u_dut1 (.clk(clk), .reset_n(rst_n[2]), .bus(bus1));

  always #5 clk = ~clk;

  assign bus2.read_b = rd_d & (sel == 0);
  assign bus2.write_b = wr_d & (sel == 0);
  assign bus2.wmask_b = mask_d;
  assign bus2.address_b = addr_d;
  assign bus2.wdata_b = wdata_d;
  assign bus4.read_b = rd_d & (sel == 1);
  assign bus4.write_b = wr_d & (sel == 1);
  assign bus4.wmask_b = mask_d;
  assign bus4.address_b = addr_d;
  assign bus4.wdata_b = wdata_d;
  assign bus1.read_b = rd_d & (sel == 2);
  assign bus1.write_b = wr_d & (sel == 2);
  assign bus1.wmask_b = mask_d;
  assign bus1.address_b = addr_d;
  assign bus1.wdata_b = wdata_d;

  always_comb begin
    case (sel)
      0:       begin resp_s = bus2.resp_b; rdata_s = bus2.rdata_b; busy_s = bus2.busy; end
      1:       begin resp_s = bus4.resp_b; rdata_s = bus4.rdata_b; busy_s = bus4.busy; end
      default: begin resp_s = bus1.resp_b; rdata_s = bus1.rdata_b; busy_s = bus1.busy; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Drive one request, hold it until resp_b, drop it after the response edge.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [1:0] mask,
                     output logic [15:0] rdata, output int lat, output int busy_cnt);
    rd_d = rd; wr_d = wr; addr_d = addr; wdata_d = wdata; mask_d = mask;
    lat = 0; busy_cnt = 0; rdata = 16'h0000;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy_s) busy_cnt++;
      if (resp_s) begin
        lat = n;
        rdata = rdata_s;
        break;
      end
    end
    @(posedge clk);
    #1;
    rd_d = 1'b0; wr_d = 1'b0;
  endtask

  initial begin
    logic [15:0] rdata;
    int lat, bcnt, gap, resp_cnt;

    rst_n = 3'b000; sel = 0;
    rd_d = 1'b0; wr_d = 1'b0; addr_d = 16'h0000; wdata_d = 16'h0000; mask_d = 2'b00;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      check("rst_resp", {31'd0, resp_s}, 32'd0);
      check("rst_busy", {31'd0, busy_s}, 32'd0);
      check("rst_rdata", {16'd0, rdata_s}, 32'h0000);
    end
    sel = 0;
    @(negedge clk);
    rst_n = 3'b111;
    @(posedge clk);
    #1;

    // LATENCY=2: full write, timing, readback
    txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, rdata, lat, bcnt);
    check("l2_wr_lat", lat, 32'd2);
    check("l2_wr_busy", bcnt, 32'd2);
    @(negedge clk);
    check("l2_no_resp_idle", {31'd0, resp_s}, 32'd0);
    check("l2_idle_busy", {31'd0, busy_s}, 32'd0);
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, rdata, lat, bcnt);
    check("l2_rd_lat", lat, 32'd2);
    check("l2_rd_data", {16'd0, rdata}, 32'hBEEF);

    // Byte-masked writes; write responses leave rdata_b alone
    txn(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, rdata, lat, bcnt);
    check("wr_keeps_rdata", {16'd0, rdata}, 32'hBEEF);
    txn(1'b0, 1'b1, 16'h0020, 16'hAACD, 2'b01, rdata, lat, bcnt);
    txn(1'b0, 1'b1, 16'h0020, 16'hEF00, 2'b10, rdata, lat, bcnt);
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, rdata, lat, bcnt);
    check("mask_merge", {16'd0, rdata}, 32'hEFCD);
    txn(1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, rdata, lat, bcnt);
    check("mask00_resp", lat, 32'd2);
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, rdata, lat, bcnt);
    check("mask00_keep", {16'd0, rdata}, 32'hEFCD);

    // Indirect-style back-to-back: address switched at the response edge
    txn(1'b0, 1'b1, 16'h0040, 16'h0080, 2'b11, rdata, lat, bcnt);
    txn(1'b0, 1'b1, 16'h0080, 16'h5A5A, 2'b11, rdata, lat, bcnt);
    txn(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, rdata, lat, bcnt);
    check("ind_ptr", {16'd0, rdata}, 32'h0080);
    rd_d = 1'b1; addr_d = 16'h0040;
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (resp_s) begin lat = n; break; end
    end
    check("ind_first_lat", lat, 32'd2);
    @(posedge clk); #1;
    addr_d = 16'h0080;
    gap = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (resp_s) begin gap = n; rdata = rdata_s; break; end
    end
    check("ind_gap", gap, 32'd3);
    check("ind_data", {16'd0, rdata}, 32'h5A5A);
    @(posedge clk); #1;
    rd_d = 1'b0;

    // Aliasing: bit0 and bits above ADDR_W ignored
    txn(1'b0, 1'b1, 16'h0201, 16'h7777, 2'b11, rdata, lat, bcnt);
    txn(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, rdata, lat, bcnt);
    check("alias", {16'd0, rdata}, 32'h7777);

    // LATENCY=4: reset mid-WAIT abandons the write
    sel = 1;
    txn(1'b0, 1'b1, 16'h0030, 16'h0101, 2'b11, rdata, lat, bcnt);
    check("l4_lat", lat, 32'd4);
    check("l4_busy", bcnt, 32'd4);
    wr_d = 1'b1; addr_d = 16'h0030; wdata_d = 16'hFFFF; mask_d = 2'b11;
    @(posedge clk);
    @(negedge clk);
    check("l4_busy_wait", {31'd0, busy_s}, 32'd1);
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    check("rst_busy_async", {31'd0, busy_s}, 32'd0);
    wr_d = 1'b0;
    resp_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (resp_s) resp_cnt++;
    end
    check("rst_no_resp", resp_cnt, 32'd0);
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    resp_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (resp_s) resp_cnt++;
    end
    check("post_rst_no_resp", resp_cnt, 32'd0);
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, rdata, lat, bcnt);
    check("rst_no_commit", {16'd0, rdata}, 32'h0101);

    // LATENCY=1 and combined read+write
    sel = 2;
    txn(1'b0, 1'b1, 16'h0050, 16'hAB00, 2'b11, rdata, lat, bcnt);
    check("l1_wr_lat", lat, 32'd1);
    txn(1'b1, 1'b1, 16'h0050, 16'h00C3, 2'b01, rdata, lat, bcnt);
    check("l1_rw_lat", lat, 32'd1);
    check("l1_rw_data", {16'd0, rdata}, 32'hABC3);
    txn(1'b1, 1'b0, 16'h0050, 16'h0000, 2'b00, rdata, lat, bcnt);
    check("l1_rw_stored", {16'd0, rdata}, 32'hABC3);
    @(negedge clk);
    check("l1_no_double_resp", {31'd0, resp_s}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
